gt_telemetry_link_ctrl: RTL and testbench

GT_TELEMETRY_LINK_CTRL -- requirements
Module: gt_telemetry_link_ctrl

---
 rtl/gt_telemetry_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/gt_telemetry_link_ctrl.sv | 144 ++++++++++++++
 tb/tb_gt_telemetry_link_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gt_telemetry_pkg.sv
// Shared state encodings and default timing constants for the GT telemetry link controller.
package gt_telemetry_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_WAIT_GT   = 3'd2,
    ST_ACQUIRE   = 3'd3,
    ST_LINKED    = 3'd4,
    ST_FAULT     = 3'd5
  } link_state_t;

  localparam logic [7:0]  C_PLL_RST_CYC  = 8'd32;
  localparam logic [15:0] C_LOCK_TIMEOUT = 16'hffff;
  localparam logic [15:0] C_EDGE_TIMEOUT = 16'h00ff;
  localparam logic [19:0] C_MATCH_CNT    = 20'h4ffff;
  localparam logic [15:0] C_PKT_TIMEOUT  = 16'hffff;
  localparam logic [3:0]  C_MAX_RETRY    = 4'd8;

  localparam logic [15:0] C_CNT_MAX      = 16'hffff;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level signal.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta;
  (* ASYNC_REG = "TRUE" *) logic sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/gt_telemetry_link_ctrl.sv
// Link bring-up controller: MMCM reset/lock, recovered-clock presence, packet
// match acquisition, plus saturating good/bad packet statistics.
module gt_telemetry_link_ctrl
  import gt_telemetry_pkg::*;
#(
  parameter logic [7:0]  G_PLL_RST_CYC  = C_PLL_RST_CYC,
  parameter logic [15:0] G_LOCK_TIMEOUT = C_LOCK_TIMEOUT,
  parameter logic [15:0] G_EDGE_TIMEOUT = C_EDGE_TIMEOUT,
  parameter logic [19:0] G_MATCH_CNT    = C_MATCH_CNT,
  parameter logic [15:0] G_PKT_TIMEOUT  = C_PKT_TIMEOUT,
  parameter logic [3:0]  G_MAX_RETRY    = C_MAX_RETRY
) (
  input  logic        clk_128M,
  input  logic        rst_n_128M,
  input  logic        pll_locked,
  input  logic        gt_clk_edge_128M,
  input  logic        pkt_good,
  input  logic        pkt_bad,
  input  logic        retry_req,
  input  logic        clear_cnt,
  output logic        pll_rst_out,
  output logic        datapath_en_out,
  output logic        okay_led_out,
  output logic [2:0]  state_out,
  output logic [15:0] good_cnt_out,
  output logic [15:0] bad_cnt_out,
  output logic [3:0]  retry_cnt_out
);

  link_state_t state, next_state;
  logic        lock_sync;
  logic [15:0] state_timer, edge_timer, pkt_timer;
  logic [19:0] match_cnt;
  logic [3:0]  retry_cnt;
  logic        good_evt, bad_evt, pkt_evt;
  logic        rst_done, lock_expired, edge_expired, pkt_expired, state_change;

  sync_2ff u_lock_sync (
    .clk   (clk_128M),
    .rst_n (rst_n_128M),
    .d     (pll_locked),
    .q     (lock_sync)
  );

  // A simultaneous good+bad pulse counts as bad only.
  assign bad_evt  = pkt_bad;
  assign good_evt = pkt_good & ~pkt_bad;
  assign pkt_evt  = pkt_good | pkt_bad;

  assign rst_done     = (state_timer == ({8'd0, G_PLL_RST_CYC} - 16'd1));
  assign lock_expired = (state_timer == (G_LOCK_TIMEOUT - 16'd1));
  assign edge_expired = !gt_clk_edge_128M && (edge_timer == (G_EDGE_TIMEOUT - 16'd1));
  assign pkt_expired  = !pkt_evt && (pkt_timer == (G_PKT_TIMEOUT - 16'd1));
  assign state_change = (next_state != state);

  always_comb begin
    next_state = state;
    case (state)
      ST_PLL_RST:   if (rst_done) next_state = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_sync)         next_state = ST_WAIT_GT;
        else if (lock_expired) next_state = ((retry_cnt + 4'd1) == G_MAX_RETRY) ? ST_FAULT : ST_PLL_RST;
      end
      ST_WAIT_GT: begin
        if (!lock_sync)            next_state = ST_PLL_RST;
        else if (gt_clk_edge_128M) next_state = ST_ACQUIRE;
        else if (edge_expired)     next_state = ST_PLL_RST;
      end
      ST_ACQUIRE: begin
        if (!lock_sync || edge_expired)                 next_state = ST_PLL_RST;
        else if (pkt_expired)                           next_state = ST_WAIT_GT;
        else if (!bad_evt && match_cnt == G_MATCH_CNT)  next_state = ST_LINKED;
      end
      ST_LINKED: begin
        if (!lock_sync || edge_expired) next_state = ST_PLL_RST;
        else if (pkt_expired)           next_state = ST_WAIT_GT;
        else if (bad_evt)               next_state = ST_ACQUIRE;
      end
      ST_FAULT:     if (retry_req) next_state = ST_PLL_RST;
      default:      next_state = ST_PLL_RST;
    endcase
  end

  // Outputs are decoded from next_state so they line up with the state register.
  always_ff @(posedge clk_128M) begin
    if (!rst_n_128M) begin
      state           <= ST_PLL_RST;
      state_timer     <= '0;
      edge_timer      <= '0;
      pkt_timer       <= '0;
      match_cnt       <= '0;
      retry_cnt       <= '0;
      pll_rst_out     <= 1'b1;
      datapath_en_out <= 1'b0;
      okay_led_out    <= 1'b0;
    end else begin
      state           <= next_state;
      pll_rst_out     <= (next_state == ST_PLL_RST) || (next_state == ST_FAULT);
      datapath_en_out <= (next_state == ST_ACQUIRE) || (next_state == ST_LINKED);
      okay_led_out    <= (next_state == ST_LINKED);

      if (state_change)
        state_timer <= '0;
      else if ((state == ST_PLL_RST || state == ST_WAIT_LOCK) && state_timer != C_CNT_MAX)
        state_timer <= state_timer + 16'd1;

      if (state_change || gt_clk_edge_128M)
        edge_timer <= '0;
      else if ((state == ST_WAIT_GT || state == ST_ACQUIRE || state == ST_LINKED) &&
               edge_timer != C_CNT_MAX)
        edge_timer <= edge_timer + 16'd1;

      if (state_change || pkt_evt)
        pkt_timer <= '0;
      else if ((state == ST_ACQUIRE || state == ST_LINKED) && pkt_timer != C_CNT_MAX)
        pkt_timer <= pkt_timer + 16'd1;

      // Outside ACQUIRE the match count is held at zero, so every entry starts fresh.
      if (state != ST_ACQUIRE || bad_evt)
        match_cnt <= '0;
      else if (good_evt && match_cnt != G_MATCH_CNT)
        match_cnt <= match_cnt + 20'd1;

      if ((next_state == ST_ACQUIRE && state != ST_ACQUIRE) || (state == ST_FAULT && retry_req))
        retry_cnt <= '0;
      else if (state == ST_WAIT_LOCK && !lock_sync && lock_expired && retry_cnt != 4'hf)
        retry_cnt <= retry_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk_128M) begin
    if (!rst_n_128M || clear_cnt) begin
      good_cnt_out <= '0;
      bad_cnt_out  <= '0;
    end else begin
      if (good_evt && good_cnt_out != C_CNT_MAX) good_cnt_out <= good_cnt_out + 16'd1;
      if (bad_evt && bad_cnt_out != C_CNT_MAX)   bad_cnt_out  <= bad_cnt_out + 16'd1;
    end
  end

  assign state_out     = state;
  assign retry_cnt_out = retry_cnt;

endmodule

// File: tb/tb_gt_telemetry_link_ctrl.sv
// Directed bench: main instance walks bring-up, acquire, timeouts, lock loss and stats;
// a second instance with a short lock timeout exercises retry exhaustion.
module tb_gt_telemetry_link_ctrl;

  localparam logic [2:0] S_PLL_RST = 3'd0, S_WAIT_LOCK = 3'd1, S_WAIT_GT = 3'd2,
                         S_ACQUIRE = 3'd3, S_LINKED = 3'd4, S_FAULT = 3'd5;

  logic        clk_128M = 1'b0;
  logic        rst_n_128M = 1'b0, pll_locked = 1'b0, gt_clk_edge_128M = 1'b0;
  logic        pkt_good = 1'b0, pkt_bad = 1'b0, retry_req = 1'b0, clear_cnt = 1'b0;
  logic        pll_rst_out, datapath_en_out, okay_led_out;
  logic [2:0]  state_out;
  logic [15:0] good_cnt_out, bad_cnt_out;
  logic [3:0]  retry_cnt_out;

  logic        rst_n_b = 1'b0, retry_req_b = 1'b0;
  logic        pll_locked_b = 1'b0, edge_b = 1'b0, good_b = 1'b0, bad_b = 1'b0, clear_b = 1'b0;
  logic        pll_rst_b, datapath_en_b, okay_led_b;
  logic [2:0]  state_b;
  logic [15:0] good_cnt_b, bad_cnt_b;
  logic [3:0]  retry_cnt_b;

  logic        edge_en = 1'b0;
  int          edge_div = 0;
  int          compared = 0;
  int          mismatched = 0;
  int          hi_cycles;

  gt_telemetry_link_ctrl #(
    .G_PLL_RST_CYC(8'd4), .G_LOCK_TIMEOUT(16'd64), .G_EDGE_TIMEOUT(16'd24),
    .G_MATCH_CNT(20'd5), .G_PKT_TIMEOUT(16'd8), .G_MAX_RETRY(4'd8)
  ) dut (
    .clk_128M(clk_128M), .rst_n_128M(rst_n_128M), .pll_locked(pll_locked),
    .gt_clk_edge_128M(gt_clk_edge_128M), .pkt_good(pkt_good), .pkt_bad(pkt_bad),
    .retry_req(retry_req), .clear_cnt(clear_cnt), .pll_rst_out(pll_rst_out),
    .datapath_en_out(datapath_en_out), .okay_led_out(okay_led_out), .state_out(state_out),
    .good_cnt_out(good_cnt_out), .bad_cnt_out(bad_cnt_out), .retry_cnt_out(retry_cnt_out)
  );

  gt_telemetry_link_ctrl #(
    .G_PLL_RST_CYC(8'd4), .G_LOCK_TIMEOUT(16'd16), .G_MAX_RETRY(4'd3)
  ) dut_retry (
    .clk_128M(clk_128M), .rst_n_128M(rst_n_b), .pll_locked(pll_locked_b),
    .gt_clk_edge_128M(edge_b), .pkt_good(good_b), .pkt_bad(bad_b),
    .retry_req(retry_req_b), .clear_cnt(clear_b), .pll_rst_out(pll_rst_b),
    .datapath_en_out(datapath_en_b), .okay_led_out(okay_led_b), .state_out(state_b),
    .good_cnt_out(good_cnt_b), .bad_cnt_out(bad_cnt_b), .retry_cnt_out(retry_cnt_b)
  );

  initial forever #4 clk_128M = ~clk_128M;

  // Recovered-clock edge pulses every 10 cycles, driven on the falling edge.
  initial forever begin
    @(negedge clk_128M);
    if (edge_en && edge_div == 9) begin
      edge_div = 0;
      gt_clk_edge_128M = 1'b1;
    end else begin
      edge_div = edge_en ? edge_div + 1 : 0;
      gt_clk_edge_128M = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_128M);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic good, input logic bad, input logic clr);
    pkt_good  = good;
    pkt_bad   = bad;
    clear_cnt = clr;
    tick(1);
    pkt_good  = 1'b0;
    pkt_bad   = 1'b0;
    clear_cnt = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    int n = 0;
    while (state_out != target && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput(tag, {29'd0, state_out}, {29'd0, target});
  endtask

  task automatic count_rst_high(output int n);
    n = 0;
    while (pll_rst_out && n < 50) begin
      n++;
      tick(1);
    end
  endtask

  initial begin
    $display("[TB] start");
    tick(3);
    checkOutput("rst_state", {29'd0, state_out}, {29'd0, S_PLL_RST});
    checkOutput("rst_pll_rst", {31'd0, pll_rst_out}, 32'd1);
    checkOutput("rst_dp_en", {31'd0, datapath_en_out}, 32'd0);
    checkOutput("rst_led", {31'd0, okay_led_out}, 32'd0);
    checkOutput("rst_good", {16'd0, good_cnt_out}, 32'd0);
    checkOutput("rst_retry", {28'd0, retry_cnt_out}, 32'd0);

    // Bring-up: 4-cycle MMCM reset, lock at cycle 20, then recovered-clock edges.
    rst_n_128M = 1'b1;
    count_rst_high(hi_cycles);
    checkOutput("bringup_rst_cycles", hi_cycles, 32'd4);
    checkOutput("bringup_wait_lock", {29'd0, state_out}, {29'd0, S_WAIT_LOCK});
    tick(16);
    checkOutput("bringup_still_wait_lock", {29'd0, state_out}, {29'd0, S_WAIT_LOCK});
    pll_locked = 1'b1;
    tick(2);
    checkOutput("bringup_sync_latency", {29'd0, state_out}, {29'd0, S_WAIT_LOCK});
    tick(1);
    checkOutput("bringup_wait_gt", {29'd0, state_out}, {29'd0, S_WAIT_GT});
    edge_en = 1'b1;
    wait_state(S_ACQUIRE, 15, "bringup_acquire");
    checkOutput("bringup_dp_en", {31'd0, datapath_en_out}, 32'd1);

    // Acquire: five consecutive goods, LINKED the cycle after the fifth.
    repeat (4) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick(1);
    end
    checkOutput("acq_after4", {29'd0, state_out}, {29'd0, S_ACQUIRE});
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("acq_count_reached", {29'd0, state_out}, {29'd0, S_ACQUIRE});
    tick(1);
    checkOutput("acq_linked", {29'd0, state_out}, {29'd0, S_LINKED});
    checkOutput("acq_led", {31'd0, okay_led_out}, 32'd1);

    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("linked_bad_state", {29'd0, state_out}, {29'd0, S_ACQUIRE});
    checkOutput("linked_bad_led", {31'd0, okay_led_out}, 32'd0);
    repeat (3) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick(1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(1);
    repeat (4) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick(1);
    end
    checkOutput("acq_bad_run_after4", {29'd0, state_out}, {29'd0, S_ACQUIRE});
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(1);
    checkOutput("acq_bad_run_linked", {29'd0, state_out}, {29'd0, S_LINKED});

    // Timeouts: no packets for 8 cycles, then no edges for 24 cycles.
    edge_en = 1'b0;
    tick(7);
    checkOutput("pkt_to_before", {29'd0, state_out}, {29'd0, S_LINKED});
    tick(1);
    checkOutput("pkt_to_wait_gt", {29'd0, state_out}, {29'd0, S_WAIT_GT});
    checkOutput("pkt_to_dp_en", {31'd0, datapath_en_out}, 32'd0);
    tick(23);
    checkOutput("edge_to_before", {29'd0, state_out}, {29'd0, S_WAIT_GT});
    tick(1);
    checkOutput("edge_to_pll_rst", {29'd0, state_out}, {29'd0, S_PLL_RST});
    checkOutput("edge_to_rst_out", {31'd0, pll_rst_out}, 32'd1);

    // Relink, then drop lock: PLL_RST three cycles later.
    edge_en = 1'b1;
    wait_state(S_ACQUIRE, 40, "relink_acquire");
    repeat (5) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick(1);
    end
    checkOutput("relink_linked", {29'd0, state_out}, {29'd0, S_LINKED});
    pll_locked = 1'b0;
    tick(2);
    checkOutput("lockloss_pending", {29'd0, state_out}, {29'd0, S_LINKED});
    tick(1);
    checkOutput("lockloss_state", {29'd0, state_out}, {29'd0, S_PLL_RST});
    checkOutput("lockloss_led", {31'd0, okay_led_out}, 32'd0);
    checkOutput("lockloss_dp_en", {31'd0, datapath_en_out}, 32'd0);
    edge_en = 1'b0;

    // Statistics: totals so far, clear, good+bad collision, saturation, clear priority.
    checkOutput("stat_good_total", {16'd0, good_cnt_out}, 32'd18);
    checkOutput("stat_bad_total", {16'd0, bad_cnt_out}, 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("stat_clear_good", {16'd0, good_cnt_out}, 32'd0);
    checkOutput("stat_clear_bad", {16'd0, bad_cnt_out}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("stat_both_good", {16'd0, good_cnt_out}, 32'd0);
    checkOutput("stat_both_bad", {16'd0, bad_cnt_out}, 32'd1);
    pkt_good = 1'b1;
    tick(70000);
    pkt_good = 1'b0;
    checkOutput("stat_saturate", {16'd0, good_cnt_out}, 32'h0000ffff);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("stat_clear_prio_good", {16'd0, good_cnt_out}, 32'd0);
    checkOutput("stat_clear_prio_bad", {16'd0, bad_cnt_out}, 32'd0);

    // Reset mid-operation, including mid-PLL_RST, restarts the reset count.
    applyStimulus(1'b1, 1'b0, 1'b0);
    rst_n_128M = 1'b0;
    tick(1);
    checkOutput("midrst_state", {29'd0, state_out}, {29'd0, S_PLL_RST});
    checkOutput("midrst_good", {16'd0, good_cnt_out}, 32'd0);
    checkOutput("midrst_retry", {28'd0, retry_cnt_out}, 32'd0);
    rst_n_128M = 1'b1;
    tick(2);
    rst_n_128M = 1'b0;
    tick(1);
    rst_n_128M = 1'b1;
    count_rst_high(hi_cycles);
    checkOutput("midrst_rst_cycles", hi_cycles, 32'd4);

    // Retry exhaustion on the short-timeout instance with lock held low.
    rst_n_b = 1'b1;
    tick(20);
    checkOutput("retry_first_state", {29'd0, state_b}, {29'd0, S_PLL_RST});
    checkOutput("retry_first_cnt", {28'd0, retry_cnt_b}, 32'd1);
    tick(39);
    checkOutput("retry_third_wait", {29'd0, state_b}, {29'd0, S_WAIT_LOCK});
    checkOutput("retry_second_cnt", {28'd0, retry_cnt_b}, 32'd2);
    tick(1);
    checkOutput("retry_fault", {29'd0, state_b}, {29'd0, S_FAULT});
    checkOutput("retry_fault_cnt", {28'd0, retry_cnt_b}, 32'd3);
    tick(10);
    checkOutput("retry_fault_hold", {29'd0, state_b}, {29'd0, S_FAULT});
    checkOutput("retry_fault_rst_out", {31'd0, pll_rst_b}, 32'd1);
    retry_req_b = 1'b1;
    tick(1);
    retry_req_b = 1'b0;
    checkOutput("retry_req_state", {29'd0, state_b}, {29'd0, S_PLL_RST});
    checkOutput("retry_req_cnt", {28'd0, retry_cnt_b}, 32'd0);
    checkOutput("retry_req_rst_out", {31'd0, pll_rst_b}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
